// File: rtl/rx_deserializer_if.sv
// Receive-path bit stream in, parallel word out.
// The deserializer takes the slave side; the bit source/consumer takes master.
interface rx_deserializer_if #(
   parameter int W = 8
);
   localparam int CW = $clog2(W + 1);

   logic          bit_valid;
   logic          bit_in;
   logic          abort;
   logic [W-1:0]  word;
   logic          word_valid;
   logic          busy;
   logic [CW-1:0] bit_count;
   logic          frag_err;

   modport master (
      output bit_valid, bit_in, abort,
      input  word, word_valid, busy, bit_count, frag_err
   );

   modport slave (
      input  bit_valid, bit_in, abort,
      output word, word_valid, busy, bit_count, frag_err
   );
endinterface

// File: rtl/rx_deserializer.sv
// Serial-to-parallel stage: gathers W strobed bits into a word.
// Abort drops a partial word and flags it as a fragment.
module rx_deserializer #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic           clk,
   input logic           reset,
   rx_deserializer_if.slave rx
);
   localparam int CW = $clog2(W + 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [W-1:0]  shifted;
   logic [W-1:0]  word_q, word_d;
   logic          wv_q, wv_d;
   logic          fe_q, fe_d;

   // shift register contents once the incoming bit is taken
   always_comb begin
      if (MSB_FIRST) shifted = {sr_q[W-2:0], rx.bit_in};
      else           shifted = {rx.bit_in, sr_q[W-1:1]};
   end

   // next state; abort wins over a bit in the same cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      word_d  = word_q;
      wv_d    = 1'b0;
      fe_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rx.bit_valid && !rx.abort) begin
               state_d = COLLECT;
               cnt_d   = CW'(1);
               sr_d    = shifted;
            end
         end
         COLLECT: begin
            if (rx.abort) begin
               fe_d    = 1'b1;
               cnt_d   = '0;
               sr_d    = '0;
               state_d = IDLE;
            end else if (rx.bit_valid) begin
               if (cnt_q == CW'(W - 1)) begin
                  word_d  = shifted;
                  wv_d    = 1'b1;
                  cnt_d   = '0;
                  sr_d    = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  sr_d  = shifted;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         word_q  <= '0;
         wv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         word_q  <= word_d;
         wv_q    <= wv_d;
         fe_q    <= fe_d;
      end
   end

   assign rx.word       = word_q;
   assign rx.word_valid = wv_q;
   assign rx.busy       = (cnt_q != '0);
   assign rx.bit_count  = cnt_q;
   assign rx.frag_err   = fe_q;
endmodule

// File: tb/tb_rx_deserializer.sv
// Bench for rx_deserializer: LSB-first and MSB-first instances share stimulus.
// A queue-based word model supplies every expected output.
module tb_rx_deserializer;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
   localparam int VW = 2 * (W + CW + 3);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rx_deserializer_if #(.W(W)) ifl ();
   rx_deserializer_if #(.W(W)) ifm ();

   rx_deserializer #(.W(W), .MSB_FIRST(1'b0)) dut_l (
      .clk   (clk),
      .reset (reset),
      .rx    (ifl.slave)
   );

   rx_deserializer #(.W(W), .MSB_FIRST(1'b1)) dut_m (
      .clk   (clk),
      .reset (reset),
      .rx    (ifm.slave)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bit           mq[$];
   logic [W-1:0] m_wl;
   logic [W-1:0] m_wm;
   logic         m_wv;
   logic         m_fe;
   logic [VW-1:0] expv;

   wire [VW-1:0] obs = {ifl.word, ifl.word_valid, ifl.busy, ifl.bit_count,
                        ifl.frag_err, ifm.word, ifm.word_valid, ifm.busy,
                        ifm.bit_count, ifm.frag_err};

   task automatic step(input logic r, input logic bv, input logic bi,
                       input logic ab);
      logic [CW-1:0] c;
      reset         = r;
      ifl.bit_valid = bv;
      ifl.bit_in    = bi;
      ifl.abort     = ab;
      ifm.bit_valid = bv;
      ifm.bit_in    = bi;
      ifm.abort     = ab;
      @(posedge clk);
      cyc++;
      m_wv = 1'b0;
      m_fe = 1'b0;
      if (r) begin
         mq.delete();
         m_wl = '0;
         m_wm = '0;
      end else if (ab) begin
         if (mq.size() != 0) m_fe = 1'b1;
         mq.delete();
      end else if (bv) begin
         mq.push_back(bi);
         if (mq.size() == W) begin
            for (int i = 0; i < W; i++) begin
               m_wl[i]       = mq[i];
               m_wm[W-1-i]   = mq[i];
            end
            m_wv = 1'b1;
            mq.delete();
         end
      end
      c = CW'(mq.size());
      expv = {m_wl, m_wv, (mq.size() != 0), c, m_fe,
              m_wm, m_wv, (mq.size() != 0), c, m_fe};
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset obs=%h exp=0", obs);
      end
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL reset_model obs=%h exp=%h", obs, expv);
      end
   endtask

   task automatic test_basic();
      logic [7:0] seq;
      seq = 8'h4D;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, seq[i], 1'b0);
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL basic_bit%0d obs=%h exp=%h", i, obs, expv);
         end
         if (i == 7) begin
            checks++;
            if (ifl.word_valid !== 1'b1 || ifl.word !== 8'h4D ||
                ifm.word !== 8'hB2) begin
               errors++;
               $display("FAIL basic_word wv=%b l=%h m=%h exp 1 4d b2",
                        ifl.word_valid, ifl.word, ifm.word);
            end
         end
         for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'b0);
            checks++;
            if (obs !== expv) begin
               errors++;
               $display("FAIL basic_gap%0d obs=%h exp=%h", i, obs, expv);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w[3];
      int pulses[$];
      w[0] = 8'hA5;
      w[1] = 8'h3C;
      w[2] = 8'hFF;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, w[n][i], 1'b0);
            checks++;
            if (obs !== expv) begin
               errors++;
               $display("FAIL b2b_w%0d_b%0d obs=%h exp=%h", n, i, obs, expv);
            end
            if (ifl.word_valid === 1'b1) pulses.push_back(cyc);
         end
         checks++;
         if (ifl.word !== w[n]) begin
            errors++;
            $display("FAIL b2b_word%0d got=%h exp=%h", n, ifl.word, w[n]);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (pulses.size() != 3) begin
         errors++;
         $display("FAIL b2b_count got=%0d exp=3", pulses.size());
      end else begin
         for (int n = 1; n < 3; n++) begin
            checks++;
            if (pulses[n] - pulses[n-1] != 8) begin
               errors++;
               $display("FAIL b2b_spacing got=%0d exp=8",
                        pulses[n] - pulses[n-1]);
            end
         end
      end
   endtask

   task automatic test_abort_partial();
      logic [W-1:0] prior;
      prior = m_wl;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
      checks++;
      if (ifl.bit_count !== 4'd5 || ifl.busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre cnt=%0d busy=%b exp 5 1",
                  ifl.bit_count, ifl.busy);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ifl.frag_err !== 1'b1 || ifl.bit_count !== '0 ||
          ifl.word !== prior || ifl.word_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_part fe=%b cnt=%0d word=%h exp 1 0 %h",
                  ifl.frag_err, ifl.bit_count, ifl.word, prior);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL abort_after obs=%h exp=%h", obs, expv);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'($urandom), 1'b0);
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL abort_fresh%0d obs=%h exp=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_abort_last();
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ifl.word_valid !== 1'b0 || ifl.frag_err !== 1'b1 ||
          ifm.frag_err !== 1'b1) begin
         errors++;
         $display("FAIL abort_last wv=%b fe=%b exp 0 1",
                  ifl.word_valid, ifl.frag_err);
      end
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL abort_last_model obs=%h exp=%h", obs, expv);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (ifl.frag_err !== 1'b0 || obs !== expv) begin
         errors++;
         $display("FAIL abort_idle obs=%h exp=%h", obs, expv);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_mid obs=%h exp=0", obs);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'($urandom), 1'b0);
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL reset_frame%0d obs=%h exp=%h", i, obs, expv);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         step(1'(($urandom % 97) == 0), 1'(($urandom % 3) != 0),
              1'($urandom), 1'(($urandom % 23) == 0));
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL random%0d obs=%h exp=%h", i, obs, expv);
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      ifl.bit_valid = 1'b0;
      ifl.bit_in    = 1'b0;
      ifl.abort     = 1'b0;
      ifm.bit_valid = 1'b0;
      ifm.bit_in    = 1'b0;
      ifm.abort     = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_abort_partial();
      test_abort_last();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
